// File: rtl/mc_datapath_regs_pkg.sv
// Shared constants for the multicycle datapath registers: width, reset PC,
// and the encodings of the result and memory-address selects.
package mc_datapath_regs_pkg;

    localparam int          XLEN             = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;
    localparam logic [1:0] RES_ZERO   = 2'b11;

    localparam logic ADDR_PC     = 1'b0;
    localparam logic ADDR_RESULT = 1'b1;

    // A taken branch and an unconditional update both redirect the PC.
    function automatic logic pc_write_en(input logic pc_update, input logic branch,
                                         input logic zero);
        return pc_update | (branch & zero);
    endfunction

endpackage

// File: rtl/mc_regfile.sv
// 32 x XLEN register file: two asynchronous read ports, one synchronous write
// port, asynchronous active-low clear, x0 hardwired to zero.
module mc_regfile
    import mc_datapath_regs_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      ra1,
    input  logic [4:0]      ra2,
    input  logic [4:0]      wa,
    input  logic            we,
    input  logic [XLEN-1:0] wd,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2
);

    logic [XLEN-1:0] regs [32];

    // NOTE: the array carries an asynchronous clear, so it maps to flops rather
    // than a RAM macro; that is intended since reset must zero every register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (wa != 5'd0)) begin
            regs[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == 5'd0) ? '0 : regs[ra1];
    assign rd2 = (ra2 == 5'd0) ? '0 : regs[ra2];

endmodule

// File: rtl/mc_datapath_regs.sv
// Architectural and inter-cycle registers of a multicycle RV32 datapath:
// PC, old PC, instruction register, latched operands, ALU and memory data.
module mc_datapath_regs
    import mc_datapath_regs_pkg::RESET_PC_DEFAULT;
    import mc_datapath_regs_pkg::RES_ALUOUT;
    import mc_datapath_regs_pkg::RES_DATA;
    import mc_datapath_regs_pkg::RES_ALU;
    import mc_datapath_regs_pkg::ADDR_PC;
    import mc_datapath_regs_pkg::pc_write_en;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      sel_result,
    input  logic            sel_mem_addr,
    input  logic            we_ir,
    input  logic            pc_update,
    input  logic            branch,
    input  logic            we_rf,
    input  logic            zero,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] mem_rdata,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] old_pc,
    output logic [XLEN-1:0] instr,
    output logic [6:0]      op,
    output logic [XLEN-1:0] rd1_q,
    output logic [XLEN-1:0] rd2_q,
    output logic [XLEN-1:0] alu_out,
    output logic [XLEN-1:0] data_q,
    output logic [XLEN-1:0] result,
    output logic [XLEN-1:0] mem_addr
);

    logic            pc_write;
    logic [XLEN-1:0] rf_rd1;
    logic [XLEN-1:0] rf_rd2;

    assign pc_write = pc_write_en(pc_update, branch, zero);
    assign op       = instr[6:0];

    // The write address comes from instr as it stands before the edge, so a
    // simultaneous instruction load never redirects the writeback.
    mc_regfile u_regfile (
        .clk (clk),
        .rst (rst),
        .ra1 (instr[19:15]),
        .ra2 (instr[24:20]),
        .wa  (instr[11:7]),
        .we  (we_rf),
        .wd  (result),
        .rd1 (rf_rd1),
        .rd2 (rf_rd2)
    );

    // NOTE: state uses non-blocking assignments so every register samples the
    // pre-edge values of its neighbours, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= RESET_PC[XLEN-1:0];
        end else if (pc_write) begin
            pc <= result;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr  <= '0;
            old_pc <= '0;
        end else if (we_ir) begin
            instr  <= mem_rdata;
            old_pc <= pc;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd1_q   <= '0;
            rd2_q   <= '0;
            alu_out <= '0;
            data_q  <= '0;
        end else begin
            rd1_q   <= rf_rd1;
            rd2_q   <= rf_rd2;
            alu_out <= alu_result;
            data_q  <= mem_rdata;
        end
    end

    // NOTE: the default assignment ahead of the case keeps this purely
    // combinational; without it an uncovered select would infer a latch.
    always_comb begin
        result = '0;
        case (sel_result)
            RES_ALUOUT: result = alu_out;
            RES_DATA:   result = data_q;
            RES_ALU:    result = alu_result;
            default:    result = '0;
        endcase
    end

    assign mem_addr = (sel_mem_addr == ADDR_PC) ? pc : result;

endmodule

// File: tb/tb_mc_datapath_regs.sv
// Directed bench for mc_datapath_regs: registered outputs are checked through
// a scoreboard queue filled when stimulus is driven and drained after the edge.
module tb_mc_datapath_regs;
    import mc_datapath_regs_pkg::*;

    localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic [1:0]  sel_result;
    logic        sel_mem_addr;
    logic        we_ir;
    logic        pc_update;
    logic        branch;
    logic        we_rf;
    logic        zero;
    logic [31:0] alu_result;
    logic [31:0] mem_rdata;
    logic [31:0] pc;
    logic [31:0] old_pc;
    logic [31:0] instr;
    logic [6:0]  op;
    logic [31:0] rd1_q;
    logic [31:0] rd2_q;
    logic [31:0] alu_out;
    logic [31:0] data_q;
    logic [31:0] result;
    logic [31:0] mem_addr;

    mc_datapath_regs #(.RESET_PC(TB_RESET_PC), .XLEN(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .sel_result   (sel_result),
        .sel_mem_addr (sel_mem_addr),
        .we_ir        (we_ir),
        .pc_update    (pc_update),
        .branch       (branch),
        .we_rf        (we_rf),
        .zero         (zero),
        .alu_result   (alu_result),
        .mem_rdata    (mem_rdata),
        .pc           (pc),
        .old_pc       (old_pc),
        .instr        (instr),
        .op           (op),
        .rd1_q        (rd1_q),
        .rd2_q        (rd2_q),
        .alu_out      (alu_out),
        .data_q       (data_q),
        .result       (result),
        .mem_addr     (mem_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum int {SIG_PC, SIG_OLD_PC, SIG_INSTR, SIG_RD1, SIG_RD2, SIG_ALU_OUT, SIG_DATA_Q} sig_e;
    typedef struct {
        sig_e        sig;
        string       tag;
        logic [31:0] exp;
    } sb_item_t;

    sb_item_t    sb[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] rf_model [32];

    function automatic logic [31:0] observe(input sig_e s);
        case (s)
            SIG_PC:      return pc;
            SIG_OLD_PC:  return old_pc;
            SIG_INSTR:   return instr;
            SIG_RD1:     return rd1_q;
            SIG_RD2:     return rd2_q;
            SIG_ALU_OUT: return alu_out;
            SIG_DATA_Q:  return data_q;
            default:     return 'x;
        endcase
    endfunction

    function automatic logic [31:0] r_instr(input logic [4:0] rd, input logic [4:0] rs1,
                                            input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b000, rd, 7'h33};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input sig_e s, input string tag, input logic [31:0] e);
        sb_item_t it;
        it.sig = s;
        it.tag = tag;
        it.exp = e;
        sb.push_back(it);
    endtask

    task automatic drain();
        while (sb.size() > 0) begin
            sb_item_t it;
            it = sb.pop_front();
            check(it.tag, observe(it.sig), it.exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        drain();
    endtask

    task automatic idle_inputs();
        sel_result   = RES_ALU;
        sel_mem_addr = ADDR_PC;
        we_ir        = 1'b0;
        pc_update    = 1'b0;
        branch       = 1'b0;
        we_rf        = 1'b0;
        zero         = 1'b0;
        alu_result   = 32'h0;
        mem_rdata    = 32'h0;
    endtask

    initial begin
        logic [4:0] prev_rs1;
        logic [4:0] prev_rs2;

        for (int i = 0; i < 32; i++) rf_model[i] = 32'h0;

        // Run with reset released and live writes so reset has state to clear.
        rst        = 1'b1;
        idle_inputs();
        we_ir      = 1'b1;
        mem_rdata  = 32'hFFFF_FFFF;
        pc_update  = 1'b1;
        alu_result = 32'h0000_0123;
        we_rf      = 1'b1;
        tick();
        tick();

        rst = 1'b0;
        #1;
        check("async_rst_pc", pc, TB_RESET_PC);
        check("async_rst_instr", instr, 32'h0);
        check("async_rst_old_pc", old_pc, 32'h0);
        check("async_rst_alu_out", alu_out, 32'h0);
        check("async_rst_data_q", data_q, 32'h0);
        check("async_rst_rd1", rd1_q, 32'h0);
        idle_inputs();
        expect_out(SIG_PC, "rst_held_pc", TB_RESET_PC);
        expect_out(SIG_INSTR, "rst_held_instr", 32'h0);
        tick();
        #2 rst = 1'b1;
        #1;
        check("rst_mem_addr", mem_addr, 32'h0);

        // Sweep every register through both read ports, one edge behind the load.
        prev_rs1 = 5'd0;
        prev_rs2 = 5'd0;
        for (int i = 1; i <= 32; i++) begin
            if (i <= 31) begin
                we_ir     = 1'b1;
                mem_rdata = r_instr(5'd0, 5'(i), 5'(32 - i));
            end else begin
                we_ir = 1'b0;
            end
            expect_out(SIG_RD1, $sformatf("rst_rd1_x%0d", prev_rs1), rf_model[prev_rs1]);
            expect_out(SIG_RD2, $sformatf("rst_rd2_x%0d", prev_rs2), rf_model[prev_rs2]);
            tick();
            prev_rs1 = 5'(i);
            prev_rs2 = 5'(32 - i);
        end
        check("post_rst_pc", pc, 32'h0);

        // Fetch.
        idle_inputs();
        mem_rdata  = 32'h0050_0093;
        we_ir      = 1'b1;
        pc_update  = 1'b1;
        sel_result = RES_ALU;
        alu_result = 32'h4;
        #1;
        check("fetch_result", result, 32'h4);
        check("fetch_mem_addr", mem_addr, 32'h0);
        expect_out(SIG_INSTR, "fetch_instr", 32'h0050_0093);
        expect_out(SIG_OLD_PC, "fetch_old_pc", 32'h0);
        expect_out(SIG_PC, "fetch_pc", 32'h4);
        expect_out(SIG_DATA_Q, "fetch_data_q", 32'h0050_0093);
        tick();
        check("fetch_op", {25'h0, op}, 32'h13);

        // Writeback of x1 through alu_out.
        idle_inputs();
        alu_result = 32'h5;
        expect_out(SIG_ALU_OUT, "wb_alu_out", 32'h5);
        expect_out(SIG_PC, "wb_pc_hold", 32'h4);
        tick();
        sel_result = RES_ALUOUT;
        we_rf      = 1'b1;
        alu_result = 32'h99;
        #1;
        check("wb_result", result, 32'h5);
        tick();
        rf_model[1] = 32'h5;

        we_rf     = 1'b0;
        we_ir     = 1'b1;
        mem_rdata = r_instr(5'd1, 5'd1, 5'd0);
        expect_out(SIG_INSTR, "rd_x1_instr", 32'h0000_80B3);
        expect_out(SIG_OLD_PC, "rd_x1_old_pc", 32'h4);
        tick();
        we_ir = 1'b0;
        expect_out(SIG_RD1, "wb_rd1_x1", rf_model[1]);
        expect_out(SIG_RD2, "wb_rd2_x0", 32'h0);
        tick();

        // Write x1 while loading a new instruction that also reads x1.
        sel_result = RES_ALU;
        alu_result = 32'h77;
        we_rf      = 1'b1;
        we_ir      = 1'b1;
        mem_rdata  = r_instr(5'd3, 5'd1, 5'd1);
        expect_out(SIG_RD1, "no_bypass_rd1", rf_model[1]);
        expect_out(SIG_INSTR, "overlap_instr", 32'h0010_81B3);
        tick();
        rf_model[1] = 32'h77;
        we_rf = 1'b0;
        we_ir = 1'b0;
        expect_out(SIG_RD1, "overlap_rd1_x1", rf_model[1]);
        expect_out(SIG_RD2, "overlap_rd2_x1", rf_model[1]);
        tick();
        we_ir     = 1'b1;
        mem_rdata = r_instr(5'd0, 5'd3, 5'd0);
        tick();
        we_ir = 1'b0;
        expect_out(SIG_RD1, "overlap_x3_untouched", rf_model[3]);
        tick();

        // Write to x0 is dropped.
        we_ir     = 1'b1;
        mem_rdata = r_instr(5'd0, 5'd0, 5'd0);
        tick();
        we_ir      = 1'b0;
        we_rf      = 1'b1;
        sel_result = RES_ALU;
        alu_result = 32'hDEAD_BEEF;
        #1;
        check("x0_result", result, 32'hDEAD_BEEF);
        tick();
        we_rf = 1'b0;
        expect_out(SIG_RD1, "x0_rd1", 32'h0);
        expect_out(SIG_RD2, "x0_rd2", 32'h0);
        tick();

        // Branch qualified by zero.
        idle_inputs();
        alu_result = 32'h40;
        expect_out(SIG_ALU_OUT, "br_alu_out", 32'h40);
        tick();
        branch     = 1'b1;
        zero       = 1'b0;
        sel_result = RES_ALUOUT;
        #1;
        check("br_result", result, 32'h40);
        expect_out(SIG_PC, "br_not_taken_pc", 32'h4);
        tick();
        zero = 1'b1;
        expect_out(SIG_PC, "br_taken_pc", 32'h40);
        tick();
        branch     = 1'b0;
        zero       = 1'b0;
        alu_result = 32'h103;
        expect_out(SIG_ALU_OUT, "misalign_alu_out", 32'h103);
        expect_out(SIG_PC, "misalign_pc_hold", 32'h40);
        tick();
        pc_update = 1'b1;
        branch    = 1'b1;
        expect_out(SIG_PC, "both_write_misaligned_pc", 32'h103);
        tick();
        pc_update = 1'b0;
        branch    = 1'b0;

        // Result and address muxes.
        sel_mem_addr = ADDR_PC;
        sel_result   = RES_ZERO;
        #1;
        check("maddr_pc", mem_addr, 32'h103);
        check("res_zero", result, 32'h0);
        sel_mem_addr = ADDR_RESULT;
        #1;
        check("maddr_result_zero", mem_addr, 32'h0);
        mem_rdata  = 32'hA5A5_0001;
        expect_out(SIG_DATA_Q, "data_q_load", 32'hA5A5_0001);
        tick();
        mem_rdata  = 32'h0;
        sel_result = RES_DATA;
        #1;
        check("res_data", result, 32'hA5A5_0001);
        check("maddr_result_data", mem_addr, 32'hA5A5_0001);
        sel_mem_addr = ADDR_PC;

        // Reset in the middle of a register-file and PC write.
        idle_inputs();
        we_ir     = 1'b1;
        mem_rdata = r_instr(5'd3, 5'd3, 5'd3);
        tick();
        we_ir      = 1'b0;
        we_rf      = 1'b1;
        alu_result = 32'h1234;
        tick();
        rf_model[3] = 32'h1234;
        alu_result  = 32'h5555;
        pc_update   = 1'b1;
        expect_out(SIG_RD1, "pre_rst_rd1_x3", rf_model[3]);
        tick();
        #3 rst = 1'b0;
        #1;
        check("mid_rst_pc_async", pc, TB_RESET_PC);
        check("mid_rst_rd1_async", rd1_q, 32'h0);
        for (int i = 0; i < 32; i++) rf_model[i] = 32'h0;
        expect_out(SIG_PC, "mid_rst_pc_edge", TB_RESET_PC);
        expect_out(SIG_INSTR, "mid_rst_instr_edge", 32'h0);
        tick();
        #2 rst = 1'b1;
        idle_inputs();
        we_ir     = 1'b1;
        mem_rdata = r_instr(5'd0, 5'd3, 5'd3);
        expect_out(SIG_INSTR, "first_edge_instr", 32'h0031_8033);
        tick();
        we_ir = 1'b0;
        expect_out(SIG_RD1, "mid_rst_x3_rd1", rf_model[3]);
        expect_out(SIG_RD2, "mid_rst_x3_rd2", rf_model[3]);
        expect_out(SIG_PC, "mid_rst_pc_after", TB_RESET_PC);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mc_datapath_regs.md
MC_DATAPATH_REGS -- requirements
Module: mc_datapath_regs

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter XLEN, default 32, datapath width; only 32 is supported.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 sel_result  in  2  result mux select: 00 alu_out, 01 data_q, 10 alu_result, 11 zero.
REQ-006 sel_mem_addr  in  1  memory address select: 0 pc, 1 result.
REQ-007 we_ir  in  1  instruction-register and old_pc load enable.
REQ-008 pc_update  in  1  unconditional PC write.
REQ-009 branch  in  1  conditional PC write, qualified by zero.
REQ-010 we_rf  in  1  register-file write enable.
REQ-011 zero  in  1  ALU zero flag, combinational from ALU.
REQ-012 alu_result  in  32  combinational ALU output.
REQ-013 mem_rdata  in  32  unified memory read data.
REQ-014 pc  out  32  current PC register.
REQ-015 old_pc  out  32  PC of the instruction held in instr.
REQ-016 instr  out  32  instruction register.
REQ-017 op  out  7  instr[6:0], to the control FSM.
REQ-018 rd1_q, rd2_q  out  32 each  latched register-file read data (A, B).
REQ-019 alu_out  out  32  ALU result latched one cycle earlier.
REQ-020 data_q  out  32  latched memory read data.
REQ-021 result  out  32  combinational result-mux output.
REQ-022 mem_addr  out  32  combinational memory address.

Function
REQ-023 pc_write = pc_update | (branch & zero); when pc_write is high, pc <= result.
REQ-024 When we_ir is high, instr <= mem_rdata and old_pc <= pc in the same edge; otherwise both hold.
REQ-025 alu_out <= alu_result and data_q <= mem_rdata on every edge, with no enable.
REQ-026 Register file: 32 x 32; read ports addressed by instr[19:15] and instr[24:20]; write port addressed by instr[11:7].
REQ-027 rd1_q and rd2_q are loaded every edge from the read ports, which reflect the array content before that edge's write (no bypass).
REQ-028 When we_rf is high and instr[11:7] != 0, the register is written with result; writes to x0 are discarded, and x0 always reads 0.
REQ-029 Simultaneous we_ir and we_rf: the write uses the instr[11:7] value from before the edge.
REQ-030 Simultaneous pc_update and branch: pc_write is high; pc <= result.
REQ-031 Output latency: all registered outputs change only at clk edges or on reset; result, mem_addr, and op are combinational.
REQ-032 PC is unmasked; misaligned values pass through unchanged.

Reset
REQ-033 On rst low: pc = RESET_PC; old_pc, instr, rd1_q, rd2_q, alu_out, data_q, and all 32 registers = 0; effect is immediate (asynchronous).
REQ-034 Reset asserted mid-instruction aborts it; no register-file or PC write completes on the edge coinciding with reset.
REQ-035 After rst is released, the first rising edge performs normal updates.

Structure
REQ-036 A shared package holds XLEN, RESET_PC default, result-select encodings (RES_ALUOUT, RES_DATA, RES_ALU, RES_ZERO), and memory-address-select encodings.
REQ-037 The register file is one sub-module, mc_regfile: 2 async read ports, 1 sync write port, async active-low clear, x0 hardwired.
REQ-038 All other registers and muxes are in mc_datapath_regs.

Verification
REQ-039 Reset then release: pc = 0, instr = 0, x1..x31 read 0; mem_addr = 0 with sel_mem_addr = 0.
REQ-040 Fetch: mem_rdata = 32'h00500093, we_ir = 1, pc_update = 1, sel_result = 10, alu_result = 4. Required response: instr = 32'h00500093, old_pc = 0, pc = 4, op = 7'h13.
REQ-041 Writeback: instr rd = x1, alu_result = 5 one cycle, then sel_result = 00 and we_rf = 1. Required response: x1 = 5, and rd1_q = 5 one edge after instr selects rs1 = x1.
REQ-042 x0 write: instr rd = 0, we_rf = 1, result = 32'hDEADBEEF. Required response: x0 still reads 0.
REQ-043 Branch: alu_out = 32'h40, branch = 1. With zero = 0, pc is unchanged. With zero = 1 and sel_result = 00, pc = 32'h40.
REQ-044 Reset mid-write: rst falls in the same cycle as we_rf = 1 for x3. Required response: x3 = 0 and pc = RESET_PC.
